// File: rtl/axi_lite_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read port (AR/R) among NUM_M masters.
// Exactly one read is in flight at a time. A grant is taken in IDLE and held
// through the address phase until the read-data handshake, after which
// priority rotates to the master after the one just served.
// Every handshake-gating output is built from registered state and grant,
// plus the granted master's own handshake inputs.
module axi_lite_rd_arbiter #(
   parameter int AXI_ADDR_WIDTH = 20,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int NUM_M          = 2,
   localparam int GW            = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_M*AXI_ADDR_WIDTH-1:0]   m_araddr,
   input  logic [NUM_M-1:0]                  m_arvalid,
   output logic [NUM_M-1:0]                  m_arready,
   output logic [NUM_M*AXI_DATA_WIDTH-1:0]   m_rdata,
   output logic [NUM_M*2-1:0]                m_rresp,
   output logic [NUM_M-1:0]                  m_rvalid,
   input  logic [NUM_M-1:0]                  m_rready,
   output logic [AXI_ADDR_WIDTH-1:0]         s_araddr,
   output logic                              s_arvalid,
   input  logic                              s_arready,
   input  logic [AXI_DATA_WIDTH-1:0]         s_rdata,
   input  logic [1:0]                        s_rresp,
   input  logic                              s_rvalid,
   output logic                              s_rready,
   output logic [GW-1:0]                     grant,
   output logic                              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t               state_reg;
   logic [GW-1:0]        grant_reg;
   logic [GW-1:0]        last_reg;
   logic                 busy_reg;

   // Arbitration result, consumed only by registers (never by outputs).
   logic                 pick_valid;
   logic [GW-1:0]        pick_idx;

   // One-hot view of the registered grant and per-master address slices.
   logic [NUM_M-1:0]           sel_vec;
   logic [AXI_ADDR_WIDTH-1:0]  addr_arr [NUM_M];
   logic [AXI_ADDR_WIDTH-1:0]  sel_addr;
   logic                       sel_arvalid;
   logic                       sel_rready;
   logic                       in_addr;
   logic                       in_data;

   assign in_addr = (state_reg == ST_ADDR);
   assign in_data = (state_reg == ST_DATA);

   // Rotating priority search: last+1, last+2, ... (mod NUM_M); the nearest
   // requester is visited last so it overrides any farther one.
   always_comb begin
      int cand;
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = NUM_M; k >= 1; k--) begin
         cand = (int'(last_reg) + k) % NUM_M;
         if (m_arvalid[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[GW-1:0];
         end
      end
   end

   // Per-master slicing and handshake steering, all keyed by the registered grant.
   generate
      for (genvar gi = 0; gi < NUM_M; gi++) begin : g_slice
         assign addr_arr[gi]  = m_araddr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
         assign sel_vec[gi]   = (grant_reg == GW'(gi));
         assign m_arready[gi] = in_addr & sel_vec[gi] & s_arready;
         assign m_rvalid[gi]  = in_data & sel_vec[gi] & s_rvalid;
         assign m_rdata[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = s_rdata;
         assign m_rresp[gi*2 +: 2] = s_rresp;
      end
   endgenerate

   // AND-OR mux of the granted master's address; other masters are masked off.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_M; i++) begin
         sel_addr = sel_addr | (addr_arr[i] & {AXI_ADDR_WIDTH{sel_vec[i]}});
      end
   end

   assign sel_arvalid = |(m_arvalid & sel_vec);
   assign sel_rready  = |(m_rready & sel_vec);

   assign s_araddr  = sel_addr;
   assign s_arvalid = in_addr & sel_arvalid;
   assign s_rready  = in_data & sel_rready;
   assign grant     = grant_reg;
   assign busy      = busy_reg;

   // Transaction sequencer: grant in IDLE, address in ADDR, response in DATA.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         grant_reg <= '0;
         last_reg  <= GW'(NUM_M - 1);
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_reg <= pick_idx;
                  state_reg <= ST_ADDR;
                  busy_reg  <= 1'b1;
               end
            end
            ST_ADDR: begin
               if (s_arvalid && s_arready) begin
                  state_reg <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (s_rvalid && s_rready) begin
                  last_reg  <= grant_reg;
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Bench for axi_lite_rd_arbiter: random masters and slave, a reference model of
// round-robin service order, and scoreboard queues checked on every handshake.
module tb_axi_lite_rd_arbiter;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int NM = 2;
   localparam int GW = (NM > 1) ? $clog2(NM) : 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [NM*AW-1:0]  m_araddr;
   logic [NM-1:0]     m_arvalid;
   logic [NM-1:0]     m_arready;
   logic [NM*DW-1:0]  m_rdata;
   logic [NM*2-1:0]   m_rresp;
   logic [NM-1:0]     m_rvalid;
   logic [NM-1:0]     m_rready;
   logic [AW-1:0]     s_araddr;
   logic              s_arvalid;
   logic              s_arready;
   logic [DW-1:0]     s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rvalid;
   logic              s_rready;
   logic [GW-1:0]     grant;
   logic              busy;

   axi_lite_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .NUM_M(NM)) dut (
      .clk(clk), .reset(reset),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef enum int {P_IDLE, P_ADDR, P_DATA} phase_t;
   typedef struct { int m; logic [AW-1:0] a; } ar_exp_t;
   typedef struct { int m; logic [DW-1:0] d; logic [1:0] r; } r_exp_t;

   ar_exp_t ar_q[$];
   r_exp_t  r_q[$];
   ar_exp_t ae;
   r_exp_t  re;

   int errors = 0;
   int checks = 0;

   // Reference model state
   phase_t phase = P_IDLE;
   int cur = 0;
   int model_last = NM - 1;
   int model_grant = 0;
   int phase_cycles = 0;
   int served[NM];
   int served_total = 0;

   // Stimulus state
   bit [NM-1:0]     mst_pend = '0;
   logic [AW-1:0]   mst_addr [NM];
   bit              slv_busy = 1'b0;
   int              slv_wait = 0;
   int req_pct = 0, arr_pct = 0, rr_pct = 0, maxd = 0;

   // Handshakes seen at the most recent edge
   bit              rst_at_edge = 1'b1;
   bit [NM-1:0]     m_ar_fire = '0;
   bit              s_ar_fire_f = 1'b0;
   bit              s_r_fire_f = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round-robin rule: first requester at last+1, last+2, ... (mod NM).
   function automatic int rr_pick(input int last, input bit [NM-1:0] req);
      for (int k = 1; k <= NM; k++) begin
         if (req[(last + k) % NM]) return (last + k) % NM;
      end
      return -1;
   endfunction

   task automatic apply_masters();
      for (int i = 0; i < NM; i++) begin
         m_arvalid[i] = mst_pend[i];
         m_araddr[i*AW +: AW] = mst_addr[i];
      end
   endtask

   // One cycle of random master and slave behaviour; AXI-compliant holding.
   task automatic drive_cycle();
      if (rst_at_edge) begin
         mst_pend = '0; slv_busy = 1'b0; slv_wait = 0;
         s_rvalid = 1'b0; s_arready = 1'b0; m_rready = '0;
         s_rdata = '0; s_rresp = '0;
      end else begin
         for (int i = 0; i < NM; i++) begin
            if (m_ar_fire[i]) mst_pend[i] = 1'b0;
            if (!mst_pend[i] && ($urandom % 100) < req_pct) begin
               mst_pend[i] = 1'b1;
               mst_addr[i] = AW'($urandom);
            end
            m_rready[i] = (($urandom % 100) < rr_pct);
         end
         if (s_r_fire_f) begin
            s_rvalid = 1'b0;
            slv_busy = 1'b0;
         end
         if (s_ar_fire_f) begin
            slv_busy = 1'b1;
            slv_wait = $urandom_range(maxd, 0);
            s_rdata  = DW'($urandom);
            s_rresp  = 2'($urandom_range(3, 0));
            r_q.push_back('{cur, s_rdata, s_rresp});
         end else if (slv_busy && !s_rvalid && slv_wait > 0) begin
            slv_wait--;
         end
         if (slv_busy && !s_rvalid && slv_wait == 0) s_rvalid = 1'b1;
         s_arready = (($urandom % 100) < arr_pct);
      end
      apply_masters();
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         drive_cycle();
      end
   endtask

   task automatic set_knobs(input int rq, input int ar, input int rr, input int md);
      req_pct = rq; arr_pct = ar; rr_pct = rr; maxd = md;
   endtask

   task automatic drain();
      int c;
      set_knobs(0, 100, 100, 0);
      c = 0;
      while ((phase != P_IDLE || mst_pend != 0) && c < 300) begin
         run(1);
         c++;
      end
      check("drain_bound", (phase == P_IDLE && mst_pend == 0), 1);
   endtask

   // Monitor and reference model: invariants, then pops on each handshake.
   always @(negedge clk) begin
      if (reset) begin
         rst_at_edge = 1'b1;
         phase = P_IDLE; model_last = NM - 1; model_grant = 0; cur = 0;
         m_ar_fire = '0; s_ar_fire_f = 1'b0; s_r_fire_f = 1'b0;
         ar_q.delete(); r_q.delete(); phase_cycles = 0;
      end else begin
         rst_at_edge = 1'b0;
         check("busy", busy, phase != P_IDLE);
         check("grant", grant, model_grant);
         check("s_arvalid", s_arvalid, phase == P_ADDR);
         check("m_arready", m_arready, (phase == P_ADDR && s_arready) ? (1 << cur) : 0);
         check("m_rvalid", m_rvalid, (phase == P_DATA && s_rvalid) ? (1 << cur) : 0);
         check("s_rready", s_rready, (phase == P_DATA) ? m_rready[cur] : 1'b0);
         m_ar_fire   = m_arvalid & m_arready;
         s_ar_fire_f = s_arvalid & s_arready;
         s_r_fire_f  = s_rvalid & s_rready;
         case (phase)
            P_IDLE: begin
               if (mst_pend != 0) begin
                  cur = rr_pick(model_last, mst_pend);
                  model_grant = cur;
                  ar_q.push_back('{cur, mst_addr[cur]});
                  phase = P_ADDR;
               end
            end
            P_ADDR: begin
               if (s_ar_fire_f) begin
                  check("ar_q_nonempty", ar_q.size() != 0, 1);
                  if (ar_q.size() != 0) begin
                     ae = ar_q.pop_front();
                     check("ar_addr", s_araddr, ae.a);
                     check("ar_grant", grant, ae.m);
                  end
                  phase = P_DATA;
               end
            end
            default: begin
               if (s_r_fire_f) begin
                  check("r_q_nonempty", r_q.size() != 0, 1);
                  if (r_q.size() != 0) begin
                     re = r_q.pop_front();
                     check("r_valid_vec", m_rvalid, 1 << re.m);
                     check("r_ready_granted", m_rready[re.m], 1);
                     for (int i = 0; i < NM; i++) begin
                        check("r_data_slice", m_rdata[i*DW +: DW], re.d);
                        check("r_resp_slice", m_rresp[i*2 +: 2], re.r);
                     end
                  end
                  served[cur]++;
                  served_total++;
                  model_last = cur;
                  phase = P_IDLE;
               end
            end
         endcase
         phase_cycles = (phase == P_IDLE) ? 0 : phase_cycles + 1;
         if (phase_cycles > 300) begin
            errors++;
            $display("FAIL txn_timeout: got stuck in phase %0d expected completion", phase);
            phase = P_IDLE; phase_cycles = 0;
            ar_q.delete(); r_q.delete();
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int c;
      for (int i = 0; i < NM; i++) begin
         served[i] = 0;
         mst_addr[i] = '0;
      end
      reset = 1'b1;
      m_araddr = '0; m_arvalid = '0; m_rready = '0;
      s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_s_arvalid", s_arvalid, 0);
      check("rst_s_rready", s_rready, 0);
      check("rst_m_arready", m_arready, 0);
      check("rst_m_rvalid", m_rvalid, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive_cycle();

      // Directed: master 0 reads 0x00010, slave returns 0xBEEF
      @(posedge clk); #1;
      mst_pend[0] = 1'b1; mst_addr[0] = 20'h00010;
      s_arready = 1'b1; m_rready = '1;
      apply_masters();
      @(posedge clk); #1;
      check("t1_s_araddr", s_araddr, 20'h00010);
      check("t1_s_arvalid_c1", s_arvalid, 1);
      @(posedge clk); #1;
      mst_pend[0] = 1'b0;
      apply_masters();
      s_rvalid = 1'b1; s_rdata = 16'hBEEF; s_rresp = 2'b00;
      r_q.push_back('{0, 16'hBEEF, 2'b00});
      #1;
      check("t1_m_rvalid_c2", m_rvalid, 2'b01);
      check("t1_m_rdata0", m_rdata[DW-1:0], 16'hBEEF);
      @(posedge clk); #1;
      s_rvalid = 1'b0; slv_busy = 1'b0;
      check("t1_idle_after", busy, 0);

      // Mixed random traffic, random SLVERR/DECERR responses included
      set_knobs(40, 60, 70, 3);
      run(1500);

      // Continuous requests from every master against a zero-wait slave
      drain();
      start = served_total;
      set_knobs(100, 100, 100, 0);
      run(300);
      check("zero_wait_reads", (served_total - start >= 98) && (served_total - start <= 100), 1);

      // Long AR stalls and long R back-pressure
      set_knobs(60, 15, 25, 5);
      run(1000);

      // Reset while holding a response in DATA
      set_knobs(100, 100, 0, 0);
      c = 0;
      while (phase != P_DATA && c < 100) begin
         run(1);
         c++;
      end
      check("reached_data", phase == P_DATA, 1);
      @(posedge clk); #1;
      drive_cycle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      drive_cycle();
      #1;
      check("rst_data_busy", busy, 0);
      check("rst_data_m_rvalid", m_rvalid, 0);
      check("rst_data_grant", grant, 0);
      check("rst_data_s_rready", s_rready, 0);
      set_knobs(100, 100, 100, 0);
      run(60);

      set_knobs(35, 50, 60, 4);
      run(800);

      drain();
      check("ar_q_empty", ar_q.size(), 0);
      check("r_q_empty", r_q.size(), 0);
      for (int i = 0; i < NM; i++) begin
         check("master_served", served[i] > 0, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
